// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter.
// Masters request with mX_valid and hold it until their mX_ready pulse. One
// winner is forwarded to the slave at a time. Every output comes straight from
// a flop. After each completion the FSM waits in DRAIN until the slave drops
// s_ready, so a lingering ready cannot complete the next request.
module mem_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        m0_valid,
  input  logic        m1_valid,
  input  logic        m0_instr,
  input  logic        m1_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;  // master currently owning the slave
  logic        last_q, last_d;    // master granted most recently
  logic        s_valid_q, s_valid_d;
  logic        s_instr_q, s_instr_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        pick1;

  // State and output registers; reset leaves master 1 as last-granted so master 0 wins the first tie
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      s_valid_q  <= 1'b0;
      s_instr_q  <= 1'b0;
      s_wstrb_q  <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      s_valid_q  <= s_valid_d;
      s_instr_q  <= s_instr_d;
      s_wstrb_q  <= s_wstrb_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the request in BUSY, wait out s_ready in DRAIN
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    s_valid_d  = s_valid_q;
    s_instr_d  = s_instr_q;
    s_wstrb_d  = s_wstrb_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    pick1      = 1'b0;

    if (m0_valid && m1_valid) begin
      pick1 = FIXED_PRIORITY ? 1'b0 : ~last_q;
    end else begin
      pick1 = m1_valid;
    end

    unique case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d   = pick1;
          s_valid_d = 1'b1;
          s_instr_d = pick1 ? m1_instr : m0_instr;
          s_wstrb_d = pick1 ? m1_wstrb : m0_wstrb;
          s_addr_d  = pick1 ? m1_addr  : m0_addr;
          s_wdata_d = pick1 ? m1_wdata : m0_wdata;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          if (grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = s_rdata;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = s_rdata;
          end
          s_valid_d = 1'b0;
          s_wstrb_d = '0;
          last_d    = grant_q;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (!s_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_valid  = s_valid_q;
  assign s_instr  = s_instr_q;
  assign s_wstrb  = s_wstrb_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin arbitration and 1 = master 0 always wins ties.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resn, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have ports m0_valid, m1_valid, input, 1 each, master request, held high until that master's ready.
REQ-005 The block SHALL have ports m0_instr, m1_instr, input, 1 each, instruction-fetch flag.
REQ-006 The block SHALL have ports m0_wstrb, m1_wstrb, input, 4 each, byte write strobes; 0 = read.
REQ-007 The block SHALL have ports m0_addr, m1_addr, m0_wdata, m1_wdata, input, 32 each, byte address and write data.
REQ-008 The block SHALL have ports m0_ready, m1_ready, output, 1 each, single-cycle completion pulse.
REQ-009 The block SHALL have ports m0_rdata, m1_rdata, output, 32 each, read data, valid while the matching ready is high.
REQ-010 The block SHALL have ports s_valid, s_instr, s_wstrb (4), s_addr (32), s_wdata (32), all outputs, driving the downstream memory controller.
REQ-011 The block SHALL have ports s_ready, input, 1, and s_rdata, input, 32, from the memory controller.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DRAIN.
REQ-014 In IDLE with at least one mX_valid high, the block SHALL select a winner, latch its instr/wstrb/addr/wdata onto the s_* outputs, set s_valid=1 and go to BUSY at the next edge.
REQ-015 Tie with FIXED_PRIORITY=0: the master not granted last SHALL win; with FIXED_PRIORITY=1: master 0 SHALL win.
REQ-016 In BUSY, s_* outputs SHALL hold constant until s_ready=1 is sampled; stalls of any length SHALL be tolerated.
REQ-017 On sampling s_ready=1 in BUSY, the block SHALL at that edge: pulse the granted mX_ready=1 for one cycle, load mX_rdata from s_rdata, clear s_valid and s_wstrb, record the grant as last-granted, and go to DRAIN.
REQ-018 In DRAIN, the block SHALL wait until s_ready=0 is sampled, then go to IDLE; a stale s_ready SHALL never complete a new request.
REQ-019 Latency with a one-cycle-ready slave SHALL be: mX_valid first high in cycle 0, s_valid in cycle 1, s_ready in cycle 2, mX_ready in cycle 3.
REQ-020 The non-granted master SHALL see mX_ready=0 and SHALL be served in the next IDLE if still requesting; no request SHALL be lost or served twice.
REQ-021 mX_rdata SHALL hold its last loaded value between transactions; it SHALL be updated for write transactions too (don't-care value).
REQ-022 A master dropping mX_valid during BUSY SHALL NOT abort the slave transaction; it completes and the ready pulse is still issued.
REQ-023 s_ready high while in IDLE SHALL be ignored.
REQ-024 m0_ready and m1_ready SHALL never be high in the same cycle.

Reset
REQ-025 While resn=0, all outputs SHALL be 0 (s_valid, s_wstrb, s_addr, s_wdata, s_instr, m0/m1_ready, m0/m1_rdata), state SHALL be IDLE, and last-granted SHALL be master 1.
REQ-026 Reset asserted mid-transaction SHALL immediately drop s_valid and abandon the transaction with no ready pulse; after release, arbitration restarts from IDLE.
REQ-027 The first request after reset SHALL be sampled at the first rising edge with resn=1.

Verification
REQ-028 Single read: m0 reads addr 0x0000_0010, slave returns 0xDEADBEEF one cycle after s_valid -> m0_ready pulses in cycle 3 with m0_rdata=0xDEADBEEF, and s_wstrb=0 throughout.
REQ-029 Simultaneous requests: m0 and m1 both valid from reset, then held re-requesting, FIXED_PRIORITY=0 -> grant order m0, m1, m0, m1; with FIXED_PRIORITY=1 -> m0 starves m1 while m0 requests.
REQ-030 Write pass-through: m1 writes addr 0x0000_0104, wdata 0x11223344, wstrb 4'b0110 -> s_* carries the identical values until s_ready, then m1_ready pulses once.
REQ-031 Slave stall: s_ready held 0 for 20 cycles -> s_* stable for all 20 cycles and no mX_ready until one cycle after s_ready rises.
REQ-032 Stale ready: s_ready held high 2 extra cycles after completion while m1 requests -> m1 is not granted until s_ready=0 is sampled, and m1 receives exactly one ready pulse.
REQ-033 Reset mid-BUSY: resn pulled low while s_valid=1 -> all outputs 0 asynchronously, with no mX_ready; after release a pending m0 request completes normally.
